vedic_mult_seq: RTL

Parametrised, sequential Vedic multiplier tile: the successor to the fixed 4x4 combinational Vedic multiplier, in the same TinyTapeout user-module pin frame. Operands stream in byte-wide over `ui_in` under a valid/ready handshake, a recursive Urdhva-Tiryagbhyam core multiplies them, and the registered 2*WIDTH-bit product is read back a byte at a time. Status and control use the bidirectional pins, split 4 in / 4 out.

---
 rtl/vedic_pkg.sv | 43 ++++
 rtl/vedic_core.sv | 97 +++++++++
 rtl/vedic_mult_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vedic_pkg.sv
// ---------------------------------------------------------------------------
// vedic_pkg
// Shared definitions for the sequential Vedic multiplier tile:
//   - state_t      : control FSM states
//   - uio bit map  : positions of the control/status bits on uio_in/uio_out
//   - UIO_OE_MASK  : fixed output-enable pattern (upper nibble driven)
//   - MUL_LAT      : cycles spent in S_MUL (1, or 2 with VEDIC_PIPE_EN)
//   - beat_count() : operand beats needed for a given operand width
// Optional feature macro: VEDIC_PIPE_EN (registered partial products).
// ---------------------------------------------------------------------------
package vedic_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // uio_in bit positions
  localparam int IN_VALID  = 0;
  localparam int OUT_SEL   = 1;
  localparam int ABORT     = 2;
  // uio_out bit positions
  localparam int IN_READY  = 4;
  localparam int OUT_VALID = 5;
  localparam int BUSY      = 6;
  localparam int BEAT_IDX  = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

`ifdef VEDIC_PIPE_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 1;
`endif

  // A 4-bit operand pair fits in one byte; 8-bit operands need two beats.
  function automatic int beat_count(input int width);
    return (width == 4) ? 1 : 2;
  endfunction

endpackage

// File: rtl/vedic_core.sv
// ---------------------------------------------------------------------------
// vedic_core
// Urdhva-Tiryagbhyam multiplier for W = 4 or 8, built from 2x2 Vedic blocks.
// The operands are split into halves; four half-width partial products
// (lo*lo, hi*lo, lo*hi, hi*hi) are formed and then summed with shifts.
// Macro VEDIC_PIPE_EN: the four partial products are registered, adding one
// cycle of latency; otherwise the core is purely combinational.
// Ports:
//   clk, rst_n, en, flush : only present with VEDIC_PIPE_EN (pipeline reg)
//   a, b   in  W          : unsigned operands
//   p      out 2*W        : unsigned product a*b
// ---------------------------------------------------------------------------
module vedic_core #(
  parameter int W = 8
) (
`ifdef VEDIC_PIPE_EN
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           flush,
`endif
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  localparam int H = W / 2;

  // 2x2 Vedic block: vertical and crosswise products with a half adder chain.
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] r;
    logic       c1;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c1   = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c1;
    r[3] = (x[1] & y[1]) & c1;
    return r;
  endfunction

  // 4x4 block composed from four 2x2 blocks.
  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = mul2(x[1:0], y[1:0]);
    q1 = mul2(x[3:2], y[1:0]);
    q2 = mul2(x[1:0], y[3:2]);
    q3 = mul2(x[3:2], y[3:2]);
    return {q3, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00};
  endfunction

  // Index 0 = lo*lo, 1 = hi(a)*lo(b), 2 = lo(a)*hi(b), 3 = hi*hi.
  logic [W-1:0] pp_next [4];
  logic [W-1:0] pp_use  [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp
      logic [H-1:0] a_half;
      logic [H-1:0] b_half;
      assign a_half = ((gi % 2) == 1) ? a[W-1:H] : a[H-1:0];
      assign b_half = ((gi / 2) == 1) ? b[W-1:H] : b[H-1:0];
      if (W == 4) begin : g_2x2
        assign pp_next[gi] = mul2(a_half, b_half);
      end else begin : g_4x4
        assign pp_next[gi] = mul4(a_half, b_half);
      end
    end
  endgenerate

`ifdef VEDIC_PIPE_EN
  logic [W-1:0] pp_reg [4];

  // Captures every enabled cycle; the operands are stable throughout S_MUL,
  // so the value seen on the second S_MUL cycle belongs to this operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pp_reg <= '{default: '0};
    end else if (en) begin
      if (flush) begin
        pp_reg <= '{default: '0};
      end else begin
        pp_reg <= pp_next;
      end
    end
  end

  assign pp_use = pp_reg;
`else
  assign pp_use = pp_next;
`endif

  // Cross terms sit H bits up; hi*hi and lo*lo concatenate without overlap.
  assign p = {pp_use[3], pp_use[0]}
           + {{H{1'b0}}, pp_use[1], {H{1'b0}}}
           + {{H{1'b0}}, pp_use[2], {H{1'b0}}};

endmodule

// File: rtl/vedic_mult_seq.sv
// ---------------------------------------------------------------------------
// vedic_mult_seq
// Sequential Vedic multiplier tile in the TinyTapeout user-module pin frame.
// Operands arrive byte-wide on ui_in under an in_valid/in_ready handshake,
// vedic_core multiplies them, and the registered product is read back a byte
// at a time on uo_out.
// Parameter WIDTH: operand width, 4 or 8.
// Macro VEDIC_PIPE_EN: core registers its partial products (S_MUL = 2 cycles).
// Ports:
//   clk     in  1 : clock, rising edge
//   rst_n   in  1 : synchronous active-low reset (independent of ena)
//   ena     in  1 : tile enable; low freezes all state
//   ui_in   in  8 : operand data (WIDTH=4: a=[3:0], b=[7:4]; WIDTH=8: a then b)
//   uio_in  in  8 : [0] in_valid, [1] out_sel, [2] abort
//   uo_out  out 8 : product byte (WIDTH=4: whole product)
//   uio_out out 8 : [4] in_ready, [5] out_valid, [6] busy, [7] beat_idx
//   uio_oe  out 8 : constant 8'hF0
// ---------------------------------------------------------------------------
module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NBEATS = beat_count(WIDTH);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [WIDTH-1:0]     b_reg, b_next;
  logic [2*WIDTH-1:0]   prod_reg, prod_next;
  logic [2*WIDTH-1:0]   core_p;
  logic                 out_valid_reg, out_valid_next;

  logic                 in_valid, out_sel, abort;
  logic                 in_ready, busy, beat_idx, accept, mul_last;
  logic [WIDTH-1:0]     beat_lo, beat_hi;
  logic                 unused_uio;

  assign in_valid = uio_in[IN_VALID];
  assign out_sel  = uio_in[OUT_SEL];
  assign abort    = uio_in[ABORT];
  assign unused_uio = &{1'b0, uio_in[7:3], out_sel};

  assign in_ready = (state_reg != S_MUL);
  assign busy     = (state_reg == S_MUL);
  assign beat_idx = (state_reg == S_B);
  assign accept   = in_ready & in_valid;

  // Operand fields within a beat: packed pair for 4-bit, whole byte for 8-bit.
  generate
    if (WIDTH == 4) begin : g_beat4
      assign beat_lo = ui_in[3:0];
      assign beat_hi = ui_in[7:4];
    end else begin : g_beat8
      assign beat_lo = ui_in;
      assign beat_hi = ui_in;
    end
  endgenerate

`ifdef VEDIC_PIPE_EN
  logic mul_cnt_reg, mul_cnt_next;
  assign mul_last = mul_cnt_reg;
`else
  assign mul_last = 1'b1;
`endif

  vedic_core #(.W(WIDTH)) u_core (
`ifdef VEDIC_PIPE_EN
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .flush (abort),
`endif
    .a     (a_reg),
    .b     (b_reg),
    .p     (core_p)
  );

  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    prod_next      = prod_reg;
    out_valid_next = out_valid_reg;
`ifdef VEDIC_PIPE_EN
    mul_cnt_next   = mul_cnt_reg;
`endif
    if (ena) begin
      if (abort) begin
        // Abort beats any simultaneous accept; the product is kept.
        state_next     = S_A;
        a_next         = '0;
        b_next         = '0;
        out_valid_next = 1'b0;
`ifdef VEDIC_PIPE_EN
        mul_cnt_next   = 1'b0;
`endif
      end else begin
        case (state_reg)
          S_A, S_DONE: begin
            // A beat in S_DONE starts the next operation.
            if (accept) begin
              out_valid_next = 1'b0;
              a_next         = beat_lo;
              if (NBEATS == 1) begin
                b_next     = beat_hi;
                state_next = S_MUL;
              end else begin
                state_next = S_B;
              end
            end
          end
          S_B: begin
            if (accept) begin
              b_next     = beat_hi;
              state_next = S_MUL;
            end
          end
          S_MUL: begin
            if (mul_last) begin
              prod_next      = core_p;
              out_valid_next = 1'b1;
              state_next     = S_DONE;
`ifdef VEDIC_PIPE_EN
              mul_cnt_next   = 1'b0;
`endif
            end else begin
`ifdef VEDIC_PIPE_EN
              mul_cnt_next   = 1'b1;
`endif
            end
          end
          default: state_next = S_A;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_A;
      a_reg         <= '0;
      b_reg         <= '0;
      prod_reg      <= '0;
      out_valid_reg <= 1'b0;
`ifdef VEDIC_PIPE_EN
      mul_cnt_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      prod_reg      <= prod_next;
      out_valid_reg <= out_valid_next;
`ifdef VEDIC_PIPE_EN
      mul_cnt_reg   <= mul_cnt_next;
`endif
    end
  end

  generate
    if (WIDTH == 4) begin : g_out4
      assign uo_out = prod_reg;
    end else begin : g_out8
      assign uo_out = out_sel ? prod_reg[2*WIDTH-1:WIDTH] : prod_reg[WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    uio_out            = '0;
    uio_out[IN_READY]  = in_ready;
    uio_out[OUT_VALID] = out_valid_reg;
    uio_out[BUSY]      = busy;
    uio_out[BEAT_IDX]  = beat_idx;
  end

  assign uio_oe = UIO_OE_MASK;

endmodule
